ctrl_pipe_unit: RTL and testbench



---
 rtl/ctrl_pkg.sv | 76 +++++++
 rtl/ctrl_decode.sv | 156 +++++++++++++++
 rtl/ctrl_pipe_unit.sv | 120 ++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and the decoded control word for the pipelined control unit.
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_CSRRW = 3'b001;

    // Channel index is sized for the largest supported GPIO count (8).
    localparam int CHAN_W = 3;

    typedef enum logic [3:0] {
        ALU_AND    = 4'b0000,
        ALU_OR     = 4'b0001,
        ALU_XOR    = 4'b0010,
        ALU_ADD    = 4'b0011,
        ALU_SUB    = 4'b0100,
        ALU_MUL    = 4'b0101,
        ALU_MULH   = 4'b0110,
        ALU_MULHSU = 4'b0111,
        ALU_SLL    = 4'b1000,
        ALU_SRL    = 4'b1001,
        ALU_SRA    = 4'b1010,
        ALU_SLT    = 4'b1100,
        ALU_SLTU   = 4'b1101,
        ALU_DIV    = 4'b1110,
        ALU_REM    = 4'b1111
    } aluop_e;

    typedef enum logic [1:0] {
        SRC_RS2   = 2'b00,
        SRC_IMM12 = 2'b01,
        SRC_UPPER = 2'b10
    } alusrc_e;

    typedef enum logic [1:0] {
        SEL_PC4   = 2'b00,
        SEL_UPPER = 2'b01,
        SEL_ALU   = 2'b10,
        SEL_CSR   = 2'b11
    } regsel_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10,
        PC_JALR   = 2'b11
    } pcsrc_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        alusrc_e           alusrc;
        aluop_e            aluop;
        regsel_e           regsel;
        logic              regwrite;
        logic              is_branch;
        logic              is_jal;
        logic              is_jalr;
        logic              is_md;
        logic              csr_in_hit;
        logic              csr_out_hit;
        logic [CHAN_W-1:0] chan;
        logic [2:0]        funct3;
        logic              illegal;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: fetched instruction to control word.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int          NUM_GPIO      = 1,
    parameter logic [11:0] GPIO_IN_BASE  = 12'hF00,
    parameter logic [11:0] GPIO_OUT_BASE = 12'hF02
) (
    input  logic [31:0] instr,
    output ctrl_word_t  cw
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr;
    logic [12:0] in_off;
    logic [12:0] out_off;
    logic        in_hit;
    logic        out_hit;
    logic        unused_instr_bits;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign csr     = instr[31:20];
    assign in_off  = {1'b0, csr} - {1'b0, GPIO_IN_BASE};
    assign out_off = {1'b0, csr} - {1'b0, GPIO_OUT_BASE};
    assign in_hit  = (csr >= GPIO_IN_BASE)  && (in_off  < 13'(NUM_GPIO));
    assign out_hit = (csr >= GPIO_OUT_BASE) && (out_off < 13'(NUM_GPIO));

    // Register indices are handled by the datapath, not by control.
    assign unused_instr_bits = ^{instr[11:7], instr[19:15]};

    // Decode opcode/funct fields; anything undecodable collapses to a bare illegal word.
    always_comb begin
        cw        = '0;
        cw.funct3 = funct3;
        case (opcode)
            OPC_R: begin
                cw.alusrc   = SRC_RS2;
                cw.regsel   = SEL_ALU;
                cw.regwrite = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  cw.aluop = ALU_ADD;
                            3'b001:  cw.aluop = ALU_SLL;
                            3'b010:  cw.aluop = ALU_SLT;
                            3'b011:  cw.aluop = ALU_SLTU;
                            3'b100:  cw.aluop = ALU_XOR;
                            3'b101:  cw.aluop = ALU_SRL;
                            3'b110:  cw.aluop = ALU_OR;
                            default: cw.aluop = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  cw.aluop = ALU_SUB;
                            3'b101:  cw.aluop = ALU_SRA;
                            default: cw.illegal = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        case (funct3)
                            3'b000:  cw.aluop = ALU_MUL;
                            3'b001:  cw.aluop = ALU_MULH;
                            3'b010:  cw.aluop = ALU_MULHSU;
                            3'b011:  cw.aluop = ALU_MULHSU;
                            3'b100:  cw.aluop = ALU_DIV;
                            3'b101:  cw.aluop = ALU_DIV;
                            default: cw.aluop = ALU_REM;
                        endcase
                        // Only DIV/DIVU/REM/REMU go through the multi-cycle handshake.
                        cw.is_md = funct3[2];
                    end
                    default: cw.illegal = 1'b1;
                endcase
            end
            OPC_IMM: begin
                cw.alusrc   = SRC_IMM12;
                cw.regsel   = SEL_ALU;
                cw.regwrite = 1'b1;
                case (funct3)
                    3'b000: cw.aluop = ALU_ADD;
                    3'b010: cw.aluop = ALU_SLT;
                    3'b011: cw.aluop = ALU_SLTU;
                    3'b100: cw.aluop = ALU_XOR;
                    3'b110: cw.aluop = ALU_OR;
                    3'b111: cw.aluop = ALU_AND;
                    3'b001: begin
                        cw.aluop = ALU_SLL;
                        if (funct7 != 7'b0000000) cw.illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == 7'b0000000)      cw.aluop = ALU_SRL;
                        else if (funct7 == 7'b0100000) cw.aluop = ALU_SRA;
                        else                           cw.illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                cw.alusrc   = SRC_UPPER;
                cw.aluop    = ALU_ADD;
                cw.regsel   = SEL_UPPER;
                cw.regwrite = 1'b1;
            end
            OPC_JAL: begin
                cw.regsel   = SEL_PC4;
                cw.regwrite = 1'b1;
                cw.is_jal   = 1'b1;
            end
            OPC_JALR: begin
                cw.alusrc   = SRC_IMM12;
                cw.aluop    = ALU_ADD;
                cw.regsel   = SEL_PC4;
                cw.regwrite = 1'b1;
                cw.is_jalr  = 1'b1;
                if (funct3 != 3'b000) cw.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                cw.is_branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: cw.aluop = ALU_SUB;
                    3'b100, 3'b101: cw.aluop = ALU_SLT;
                    3'b110, 3'b111: cw.aluop = ALU_SLTU;
                    default:        cw.illegal = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                if (funct3 != F3_CSRRW) begin
                    cw.illegal = 1'b1;
                end else if (out_hit) begin
                    // Where the two windows overlap, the write channel wins.
                    cw.regsel      = SEL_CSR;
                    cw.regwrite    = 1'b1;
                    cw.csr_out_hit = 1'b1;
                    cw.chan        = out_off[CHAN_W-1:0];
                end else if (in_hit) begin
                    cw.regsel     = SEL_CSR;
                    cw.regwrite   = 1'b1;
                    cw.csr_in_hit = 1'b1;
                    cw.chan       = in_off[CHAN_W-1:0];
                end
            end
            default: cw.illegal = 1'b1;
        endcase

        if (cw.illegal) begin
            cw         = '0;
            cw.illegal = 1'b1;
            cw.funct3  = funct3;
        end
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// EX-stage control register, DIV/REM sequencing FSM, branch resolution and qualification.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int          NUM_GPIO      = 1,
    parameter logic [11:0] GPIO_IN_BASE  = 12'hF00,
    parameter logic [11:0] GPIO_OUT_BASE = 12'hF02,
    localparam int         RSEL_W        = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid_F,
    input  logic [31:0]         instr_F,
    input  logic                br_cond_EX,
    input  logic                md_done,
    output logic                valid_EX,
    output logic [1:0]          alusrc_EX,
    output logic [3:0]          aluop_EX,
    output logic [1:0]          regsel_EX,
    output logic                regwrite_EX,
    output logic [1:0]          pcsrc_EX,
    output logic [NUM_GPIO-1:0] gpio_we_EX,
    output logic [RSEL_W-1:0]   gpio_rsel_EX,
    output logic                md_start,
    output logic                stall_F,
    output logic                flush_F,
    output logic                illegal_EX
);

    ctrl_word_t  dec_cw;
    ctrl_word_t  ex_d, ex_q;
    logic        valid_d, valid_q;
    ctrl_state_e state_d, state_q;
    logic        md_ack;
    logic        unused_ex_bits;

    ctrl_decode #(
        .NUM_GPIO      (NUM_GPIO),
        .GPIO_IN_BASE  (GPIO_IN_BASE),
        .GPIO_OUT_BASE (GPIO_OUT_BASE)
    ) u_decode (
        .instr (instr_F),
        .cw    (dec_cw)
    );

    assign valid_EX     = valid_q;
    assign alusrc_EX    = ex_q.alusrc;
    assign aluop_EX     = ex_q.aluop;
    assign regsel_EX    = ex_q.regsel;
    assign gpio_rsel_EX = ex_q.chan[RSEL_W-1:0];
    assign illegal_EX   = valid_q & ex_q.illegal;
    assign md_ack       = (state_q == ST_MD_WAIT) & md_done;

    // Read-side CSR hit and the upper funct3 bits only matter inside decode.
    assign unused_ex_bits = ^{ex_q.csr_in_hit, ex_q.funct3[2:1], ex_q.chan};

    // FSM next state, redirect/stall/start outputs, write qualification and EX load.
    always_comb begin
        state_d     = state_q;
        ex_d        = ex_q;
        valid_d     = valid_q;
        md_start    = 1'b0;
        stall_F     = 1'b0;
        pcsrc_EX    = PC_SEQ;
        regwrite_EX = 1'b0;
        gpio_we_EX  = '0;

        case (state_q)
            ST_RUN: begin
                if (valid_q && ex_q.is_md) begin
                    md_start = 1'b1;
                    stall_F  = 1'b1;
                    state_d  = ST_MD_WAIT;
                end
            end
            default: begin
                if (md_done) state_d = ST_RUN;
                else         stall_F = 1'b1;
            end
        endcase

        if (valid_q) begin
            if (ex_q.is_jal)                                        pcsrc_EX = PC_JAL;
            else if (ex_q.is_jalr)                                  pcsrc_EX = PC_JALR;
            else if (ex_q.is_branch && (br_cond_EX ^ ex_q.funct3[0])) pcsrc_EX = PC_BRANCH;

            regwrite_EX = ex_q.regwrite & (~ex_q.is_md | md_ack);

            for (int k = 0; k < NUM_GPIO; k++) begin
                if (ex_q.csr_out_hit && (ex_q.chan == CHAN_W'(k))) gpio_we_EX[k] = 1'b1;
            end
        end

        flush_F = (pcsrc_EX != PC_SEQ);

        if (!stall_F) begin
            if (flush_F || !instr_valid_F) begin
                valid_d = 1'b0;
                ex_d    = '0;
            end else begin
                valid_d = 1'b1;
                ex_d    = dec_cw;
            end
        end
    end

    // EX register and FSM state; reset empties EX and returns to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ex_q    <= ex_d;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed self-checking bench for ctrl_pipe_unit with four GPIO channels.
module tb_ctrl_pipe_unit;

    localparam int NG = 4;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_ADDI  = 32'h00508213;
    localparam logic [31:0] I_DIV   = 32'h0220C2B3;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BLT   = 32'h0020C463;
    localparam logic [31:0] I_JALR  = 32'h000280E7;
    localparam logic [31:0] I_CSR_O = 32'hF0509373;
    localparam logic [31:0] I_CSR_I = 32'hF0109373;
    localparam logic [31:0] I_CSR_N = 32'hF1009373;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid_F = 1'b0;
    logic [31:0]   instr_F = '0;
    logic          br_cond_EX = 1'b0;
    logic          md_done = 1'b0;
    logic          valid_EX;
    logic [1:0]    alusrc_EX;
    logic [3:0]    aluop_EX;
    logic [1:0]    regsel_EX;
    logic          regwrite_EX;
    logic [1:0]    pcsrc_EX;
    logic [NG-1:0] gpio_we_EX;
    logic [1:0]    gpio_rsel_EX;
    logic          md_start;
    logic          stall_F;
    logic          flush_F;
    logic          illegal_EX;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(
        .NUM_GPIO      (NG),
        .GPIO_IN_BASE  (12'hF00),
        .GPIO_OUT_BASE (12'hF02)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_F (instr_valid_F),
        .instr_F       (instr_F),
        .br_cond_EX    (br_cond_EX),
        .md_done       (md_done),
        .valid_EX      (valid_EX),
        .alusrc_EX     (alusrc_EX),
        .aluop_EX      (aluop_EX),
        .regsel_EX     (regsel_EX),
        .regwrite_EX   (regwrite_EX),
        .pcsrc_EX      (pcsrc_EX),
        .gpio_we_EX    (gpio_we_EX),
        .gpio_rsel_EX  (gpio_rsel_EX),
        .md_start      (md_start),
        .stall_F       (stall_F),
        .flush_F       (flush_F),
        .illegal_EX    (illegal_EX)
    );

    // Present an instruction in fetch so the next rising edge loads it into EX.
    task automatic drive(input logic v, input logic [31:0] ins);
        @(negedge clk);
        instr_valid_F = v;
        instr_F       = ins;
        br_cond_EX    = 1'b0;
        md_done       = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        instr_valid_F = 1'b1;
        instr_F       = I_ADD;
        md_done       = 1'b1;
        #1;
        total++; if (valid_EX !== 1'b0) $display("[TB] FAIL rst_valid: got %0h expected 0", valid_EX); else passed++;
        total++; if (regwrite_EX !== 1'b0) $display("[TB] FAIL rst_regwrite: got %0h expected 0", regwrite_EX); else passed++;
        total++; if ({md_start, stall_F, flush_F, pcsrc_EX} !== 5'b0) $display("[TB] FAIL rst_ctrl: got %0h expected 0", {md_start, stall_F, flush_F, pcsrc_EX}); else passed++;
        @(posedge clk); #1;
        total++; if ({valid_EX, aluop_EX, alusrc_EX, regsel_EX, gpio_we_EX, illegal_EX} !== 14'b0) $display("[TB] FAIL rst_held: got %0h expected 0", {valid_EX, aluop_EX, alusrc_EX, regsel_EX, gpio_we_EX, illegal_EX}); else passed++;
        @(negedge clk);
        rst_n         = 1'b1;
        instr_valid_F = 1'b0;
        md_done       = 1'b0;
    endtask

    task automatic test_alu_ops();
        drive(1'b1, I_ADD);
        @(negedge clk); instr_F = I_ADDI; #1;
        total++; if (valid_EX !== 1'b1) $display("[TB] FAIL add_valid: got %0h expected 1", valid_EX); else passed++;
        total++; if (aluop_EX !== 4'b0011) $display("[TB] FAIL add_aluop: got %0h expected 3", aluop_EX); else passed++;
        total++; if (alusrc_EX !== 2'b00) $display("[TB] FAIL add_alusrc: got %0h expected 0", alusrc_EX); else passed++;
        total++; if ({regsel_EX, regwrite_EX, flush_F} !== 4'b1010) $display("[TB] FAIL add_wb: got %0h expected a", {regsel_EX, regwrite_EX, flush_F}); else passed++;
        @(negedge clk); instr_valid_F = 1'b0; #1;
        total++; if (alusrc_EX !== 2'b01) $display("[TB] FAIL addi_alusrc: got %0h expected 1", alusrc_EX); else passed++;
        total++; if ({aluop_EX, regsel_EX, regwrite_EX} !== 7'b0011_10_1) $display("[TB] FAIL addi_ctrl: got %0h expected 1d", {aluop_EX, regsel_EX, regwrite_EX}); else passed++;
        @(negedge clk); #1;
        total++; if ({valid_EX, regwrite_EX} !== 2'b00) $display("[TB] FAIL invalid_bubble: got %0h expected 0", {valid_EX, regwrite_EX}); else passed++;
    endtask

    task automatic test_div();
        int stall_cnt = 0;
        int start_cnt = 0;
        drive(1'b1, I_DIV);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            instr_F = I_ADD;
            md_done = (c == 0) || (c == 5);
            #1;
            stall_cnt += int'(stall_F);
            start_cnt += int'(md_start);
            total++; if (regwrite_EX !== (c == 5)) $display("[TB] FAIL div_regwrite_c%0d: got %0h expected %0h", c, regwrite_EX, (c == 5)); else passed++;
            if (c == 2) begin
                total++; if ({valid_EX, aluop_EX} !== 5'b1_1110) $display("[TB] FAIL div_hold: got %0h expected 1e", {valid_EX, aluop_EX}); else passed++;
            end
        end
        total++; if (stall_cnt !== 5) $display("[TB] FAIL div_stall_cycles: got %0d expected 5", stall_cnt); else passed++;
        total++; if (start_cnt !== 1) $display("[TB] FAIL div_start_pulses: got %0d expected 1", start_cnt); else passed++;
        @(negedge clk); md_done = 1'b0; instr_valid_F = 1'b0; #1;
        total++; if ({valid_EX, aluop_EX, regwrite_EX, stall_F} !== 7'b1_0011_1_0) $display("[TB] FAIL div_next: got %0h expected 4e", {valid_EX, aluop_EX, regwrite_EX, stall_F}); else passed++;
    endtask

    task automatic test_branch();
        drive(1'b1, I_BNE);
        @(negedge clk); br_cond_EX = 1'b1; instr_F = I_ADDI; #1;
        total++; if ({pcsrc_EX, flush_F} !== 3'b000) $display("[TB] FAIL bne_not_taken: got %0h expected 0", {pcsrc_EX, flush_F}); else passed++;
        total++; if ({valid_EX, aluop_EX, regwrite_EX} !== 6'b1_0100_0) $display("[TB] FAIL bne_ctrl: got %0h expected 28", {valid_EX, aluop_EX, regwrite_EX}); else passed++;
        @(negedge clk); br_cond_EX = 1'b0; instr_F = I_BLT; #1;
        total++; if ({valid_EX, alusrc_EX} !== 3'b101) $display("[TB] FAIL bne_no_bubble: got %0h expected 5", {valid_EX, alusrc_EX}); else passed++;
        @(negedge clk); br_cond_EX = 1'b1; instr_F = I_ADD; #1;
        total++; if ({pcsrc_EX, flush_F} !== 3'b011) $display("[TB] FAIL blt_taken: got %0h expected 3", {pcsrc_EX, flush_F}); else passed++;
        total++; if (aluop_EX !== 4'b1100) $display("[TB] FAIL blt_aluop: got %0h expected c", aluop_EX); else passed++;
        @(negedge clk); br_cond_EX = 1'b0; instr_valid_F = 1'b0; #1;
        total++; if ({valid_EX, regwrite_EX} !== 2'b00) $display("[TB] FAIL blt_bubble: got %0h expected 0", {valid_EX, regwrite_EX}); else passed++;
    endtask

    task automatic test_jalr();
        drive(1'b1, I_JALR);
        @(negedge clk); instr_F = I_ADD; #1;
        total++; if ({pcsrc_EX, flush_F} !== 3'b111) $display("[TB] FAIL jalr_redirect: got %0h expected 7", {pcsrc_EX, flush_F}); else passed++;
        total++; if ({regsel_EX, regwrite_EX} !== 3'b001) $display("[TB] FAIL jalr_wb: got %0h expected 1", {regsel_EX, regwrite_EX}); else passed++;
        total++; if ({alusrc_EX, aluop_EX} !== 6'b01_0011) $display("[TB] FAIL jalr_alu: got %0h expected 13", {alusrc_EX, aluop_EX}); else passed++;
        @(negedge clk); instr_valid_F = 1'b0; #1;
        total++; if ({valid_EX, regwrite_EX, pcsrc_EX} !== 4'b0) $display("[TB] FAIL jalr_bubble: got %0h expected 0", {valid_EX, regwrite_EX, pcsrc_EX}); else passed++;
    endtask

    task automatic test_gpio_csr();
        drive(1'b1, I_CSR_O);
        @(negedge clk); instr_F = I_CSR_I; #1;
        total++; if (gpio_we_EX !== 4'b1000) $display("[TB] FAIL csr_out_we: got %0h expected 8", gpio_we_EX); else passed++;
        total++; if ({regsel_EX, regwrite_EX} !== 3'b111) $display("[TB] FAIL csr_out_wb: got %0h expected 7", {regsel_EX, regwrite_EX}); else passed++;
        @(negedge clk); instr_F = I_CSR_N; #1;
        total++; if (gpio_rsel_EX !== 2'd1) $display("[TB] FAIL csr_in_rsel: got %0h expected 1", gpio_rsel_EX); else passed++;
        total++; if ({gpio_we_EX, regsel_EX, regwrite_EX} !== 7'b0000_11_1) $display("[TB] FAIL csr_in_ctrl: got %0h expected 7", {gpio_we_EX, regsel_EX, regwrite_EX}); else passed++;
        @(negedge clk); instr_F = I_ILL; #1;
        total++; if ({valid_EX, regwrite_EX, gpio_we_EX, illegal_EX} !== 7'b1_0_0000_0) $display("[TB] FAIL csr_nop: got %0h expected 40", {valid_EX, regwrite_EX, gpio_we_EX, illegal_EX}); else passed++;
        @(negedge clk); instr_valid_F = 1'b0; #1;
        total++; if ({illegal_EX, regwrite_EX, gpio_we_EX, pcsrc_EX} !== 8'b1_0_0000_00) $display("[TB] FAIL illegal_op: got %0h expected 80", {illegal_EX, regwrite_EX, gpio_we_EX, pcsrc_EX}); else passed++;
    endtask

    task automatic test_reset_md_wait();
        drive(1'b1, I_DIV);
        @(negedge clk); instr_F = I_ADD; #1;
        total++; if (md_start !== 1'b1) $display("[TB] FAIL rmd_start: got %0h expected 1", md_start); else passed++;
        @(negedge clk); #1;
        total++; if ({stall_F, md_start} !== 2'b10) $display("[TB] FAIL rmd_waiting: got %0h expected 2", {stall_F, md_start}); else passed++;
        #2; rst_n = 1'b0; #1;
        total++; if ({valid_EX, regwrite_EX, stall_F, md_start, aluop_EX} !== 8'b0) $display("[TB] FAIL rmd_async: got %0h expected 0", {valid_EX, regwrite_EX, stall_F, md_start, aluop_EX}); else passed++;
        @(negedge clk); rst_n = 1'b1; md_done = 1'b1; instr_valid_F = 1'b0; #1;
        total++; if ({regwrite_EX, stall_F, valid_EX} !== 3'b000) $display("[TB] FAIL rmd_stale_done: got %0h expected 0", {regwrite_EX, stall_F, valid_EX}); else passed++;
        @(negedge clk); md_done = 1'b0; instr_valid_F = 1'b1; instr_F = I_ADD;
        @(negedge clk); instr_valid_F = 1'b0; #1;
        total++; if ({valid_EX, regwrite_EX, stall_F} !== 3'b110) $display("[TB] FAIL rmd_run_after: got %0h expected 6", {valid_EX, regwrite_EX, stall_F}); else passed++;
    endtask

    // Run each scenario in order, then report.
    initial begin
        $display("[TB] starting ctrl_pipe_unit directed tests");
        test_reset();
        test_alu_ops();
        test_div();
        test_branch();
        test_jalr();
        test_gpio_csr();
        test_reset_md_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
